param_data_memory: RTL and testbench

//  Parametrised single-port data memory with valid/ready request handshake, bit-mask

---
 rtl/param_data_memory.sv | 157 +++++++++++++++
 tb/tb_param_data_memory.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_data_memory.sv
// Single-port data memory for the MEM stage: valid/ready request port,
// bit-masked writes, 1- or 2-cycle read latency and a self-sequenced
// initialisation sweep that writes every word once after reset or on request.
module param_data_memory #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              init_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic              vld_p0;
  logic              err_p0;
  logic [DATA_W-1:0] dat_p0;
  logic              vld_p1;
  logic              err_p1;
  logic [DATA_W-1:0] dat_p1;

  // Value written to word i by the sweep; wraps modulo 2^DATA_W when DEPTH is larger.
  function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] i);
    if (INIT_MODE == 1) return DATA_W'(i);
    else                return '0;
  endfunction

  // Bitwise merge: mask bits set take the new data, clear bits keep the old word.
  function automatic logic [DATA_W-1:0] merge_masked(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [DATA_W-1:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  // init_req has priority over a concurrent request, so ready is withdrawn in that cycle.
  assign req_ready = (state == ST_RUN) && !init_req;
  assign busy      = (state == ST_INIT);
  assign accept    = req_valid && req_ready;
  assign in_range  = ({1'b0, addr} < DEPTH_L);
  assign idx       = addr[IDX_W-1:0];

  // State and sweep counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: sweep one word per cycle in INIT, leave on the last word; init_req restarts from RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Word store: sweep writes in INIT, masked request writes in RUN; nothing while RESET is held.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == ST_INIT) begin
        mem[cnt[IDX_W-1:0]] <= init_value(cnt);
      end else if (accept && req_write && in_range) begin
        mem[idx] <= merge_masked(mem[idx], wdata, wmask);
      end
    end
  end

  // ---- stage p0: request accepted, word sampled ----
  assign vld_p0 = accept && !req_write;
  assign err_p0 = accept && !in_range;
  assign dat_p0 = in_range ? mem[idx] : '0;

  // ---- stage p1: extra delay slot used only when RD_LAT is 2 ----
  // Control of the delay slot; cleared by reset so in-flight reads are dropped.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      err_p1 <= err_p0;
    end
  end

  // Data of the delay slot.
  always_ff @(posedge CLK) begin
    dat_p1 <= dat_p0;
  end

  // ---- response: rvalid/err pulses, rdata held until the next rvalid ----
  // Response register fed from p0 (RD_LAT 1) or p1 (RD_LAT 2).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else if (RD_LAT == 2) begin
      rvalid <= vld_p1;
      err    <= err_p1;
      if (vld_p1) rdata <= dat_p1;
    end else begin
      rvalid <= vld_p0;
      err    <= err_p0;
      if (vld_p0) rdata <= dat_p0;
    end
  end

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: three instances cover the default
// configuration, RD_LAT=2 with DEPTH=200, and INIT_MODE=0 with DEPTH=16.
module tb_param_data_memory;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic [2:0]      init_req_s, req_valid_s, req_ready_s, req_write_s;
  logic [2:0]      rvalid_s, err_s, busy_s;
  logic [2:0][7:0] addr_s, wdata_s, wmask_s, rdata_s;

  int lat [3] = '{1, 2, 1};

  param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .INIT_MODE(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .init_req(init_req_s[0]), .req_valid(req_valid_s[0]),
    .req_ready(req_ready_s[0]), .req_write(req_write_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .wmask(wmask_s[0]), .rvalid(rvalid_s[0]), .rdata(rdata_s[0]),
    .err(err_s[0]), .busy(busy_s[0]));

  param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LAT(2), .INIT_MODE(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .init_req(init_req_s[1]), .req_valid(req_valid_s[1]),
    .req_ready(req_ready_s[1]), .req_write(req_write_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .wmask(wmask_s[1]), .rvalid(rvalid_s[1]), .rdata(rdata_s[1]),
    .err(err_s[1]), .busy(busy_s[1]));

  param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .RD_LAT(1), .INIT_MODE(0)) dut_c (
    .CLK(CLK), .RESET(RESET), .init_req(init_req_s[2]), .req_valid(req_valid_s[2]),
    .req_ready(req_ready_s[2]), .req_write(req_write_s[2]), .addr(addr_s[2]),
    .wdata(wdata_s[2]), .wmask(wmask_s[2]), .rvalid(rvalid_s[2]), .rdata(rdata_s[2]),
    .err(err_s[2]), .busy(busy_s[2]));

  typedef struct {
    int       cyc;
    bit       rv;
    bit       er;
    bit [7:0] data;
  } exp_t;

  exp_t q [3][$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every response slot is matched against the head of that instance's queue.
  always @(negedge CLK) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rvalid_s[d] || err_s[d]) begin
        if (q[d].size() == 0) begin
          chk($sformatf("dut%0d_unexpected_response", d), 32'({rvalid_s[d], err_s[d]}), 32'd0);
        end else begin
          e = q[d].pop_front();
          chk($sformatf("dut%0d_resp_cycle", d), 32'(cyc), 32'(e.cyc));
          chk($sformatf("dut%0d_rvalid", d), 32'(rvalid_s[d]), 32'(e.rv));
          chk($sformatf("dut%0d_err", d), 32'(err_s[d]), 32'(e.er));
          if (e.rv) chk($sformatf("dut%0d_rdata", d), 32'(rdata_s[d]), 32'(e.data));
        end
      end else if (q[d].size() != 0 && q[d][0].cyc <= cyc) begin
        e = q[d].pop_front();
        chk($sformatf("dut%0d_missing_response", d), 32'({rvalid_s[d], err_s[d]}), 32'({e.rv, e.er}));
      end
    end
  end

  // Drive one request at a negedge; expected response (if any) goes to the scoreboard.
  task automatic req(int d, bit wr, int a, int wd, int wm, int exp_d, bit exp_e);
    exp_t e;
    req_valid_s[d] = 1'b1;
    req_write_s[d] = wr;
    addr_s[d]      = 8'(a);
    wdata_s[d]     = 8'(wd);
    wmask_s[d]     = 8'(wm);
    #1;
    chk($sformatf("dut%0d_req_ready", d), 32'(req_ready_s[d]), 32'd1);
    if (!wr || exp_e) begin
      e.cyc  = cyc + lat[d];
      e.rv   = !wr;
      e.er   = exp_e;
      e.data = 8'(exp_d);
      q[d].push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic idle(int d);
    req_valid_s[d] = 1'b0;
    req_write_s[d] = 1'b0;
  endtask

  // Counts edges until busy falls; optionally pulses init_req mid-sweep (must be ignored).
  task automatic wait_sweep(int d, int exp_n, string name, int pulse_at);
    int n = 0;
    while (busy_s[d] && n < 1000) begin
      @(negedge CLK);
      n++;
      init_req_s[d] = (n == pulse_at);
    end
    init_req_s[d] = 1'b0;
    chk(name, 32'(n), 32'(exp_n));
  endtask

  // Pulse init_req together with a request that must not be accepted.
  task automatic init_with_req(int d, bit wr, int a);
    init_req_s[d]  = 1'b1;
    req_valid_s[d] = 1'b1;
    req_write_s[d] = wr;
    addr_s[d]      = 8'(a);
    wdata_s[d]     = 8'h00;
    wmask_s[d]     = 8'hFF;
    #1;
    chk($sformatf("dut%0d_ready_during_init_req", d), 32'(req_ready_s[d]), 32'd0);
    @(negedge CLK);
    init_req_s[d] = 1'b0;
    idle(d);
    chk($sformatf("dut%0d_busy_after_init_req", d), 32'(busy_s[d]), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    RESET       = 1'b1;
    init_req_s  = '0;
    req_valid_s = '0;
    req_write_s = '0;
    addr_s      = '0;
    wdata_s     = '0;
    wmask_s     = '0;
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d_reset_ready", d), 32'(req_ready_s[d]), 32'd0);
      chk($sformatf("dut%0d_reset_busy", d), 32'(busy_s[d]), 32'd1);
      chk($sformatf("dut%0d_reset_rvalid", d), 32'(rvalid_s[d]), 32'd0);
      chk($sformatf("dut%0d_reset_err", d), 32'(err_s[d]), 32'd0);
      chk($sformatf("dut%0d_reset_rdata", d), 32'(rdata_s[d]), 32'd0);
    end
    RESET = 1'b0;
    // Sweep of 256 words takes 256 edges; the init_req pulse at edge 100 must not restart it.
    wait_sweep(0, 256, "dut0_init_edges", 100);
    chk("dut1_busy_after_init", 32'(busy_s[1]), 32'd0);
    chk("dut2_busy_after_init", 32'(busy_s[2]), 32'd0);

    // Default instance: init pattern, masked writes, back-to-back reads.
    req(0, 0, 'h2A, 0, 0, 'h2A, 0);
    idle(0);
    repeat (2) @(negedge CLK);
    // (0x05 & ~0x3C) | (0xF0 & 0x3C) = 0x01 | 0x30 = 0x31
    req(0, 1, 5, 'hF0, 'h3C, 0, 0);
    req(0, 0, 5, 0, 0, 'h31, 0);
    req(0, 1, 9, 'hFF, 'h00, 0, 0);
    req(0, 0, 9, 0, 0, 'h09, 0);
    req(0, 1, 6, 'hAA, 'hFF, 0, 0);
    req(0, 0, 6, 0, 0, 'hAA, 0);
    req(0, 0, 0, 0, 0, 'h00, 0);
    req(0, 0, 255, 0, 0, 'hFF, 0);
    idle(0);
    repeat (3) @(negedge CLK);

    // init_req beats a concurrent write; sweep restores word 7.
    init_with_req(0, 1, 7);
    wait_sweep(0, 256, "dut0_reinit_edges", 0);
    req(0, 0, 7, 0, 0, 'h07, 0);
    idle(0);

    // RD_LAT=2 instance: pipelined reads, out-of-range accesses.
    req(1, 0, 1, 0, 0, 1, 0);
    req(1, 0, 2, 0, 0, 2, 0);
    req(1, 0, 3, 0, 0, 3, 0);
    idle(1);
    repeat (3) @(negedge CLK);
    req(1, 0, 210, 0, 0, 0, 1);
    req(1, 1, 210, 'h12, 'hFF, 0, 1);
    req(1, 0, 199, 0, 0, 'hC7, 0);
    idle(1);
    repeat (3) @(negedge CLK);
    // A read already in flight when init_req arrives still returns pre-init data.
    req(1, 1, 4, 'hEE, 'hFF, 0, 0);
    req(1, 0, 4, 0, 0, 'hEE, 0);
    idle(1);
    init_req_s[1] = 1'b1;
    @(negedge CLK);
    init_req_s[1] = 1'b0;
    wait_sweep(1, 200, "dut1_reinit_edges", 0);
    req(1, 0, 4, 0, 0, 'h04, 0);
    idle(1);

    // INIT_MODE=0 instance.
    req(2, 0, 5, 0, 0, 0, 0);
    req(2, 0, 15, 0, 0, 0, 0);
    req(2, 0, 16, 0, 0, 0, 1);
    req(2, 1, 5, 'h77, 'hFF, 0, 0);
    req(2, 0, 5, 0, 0, 'h77, 0);
    idle(2);
    repeat (2) @(negedge CLK);
    init_with_req(2, 0, 5);
    wait_sweep(2, 16, "dut2_reinit_edges", 0);
    req(2, 0, 5, 0, 0, 0, 0);
    idle(2);

    // Reset during an in-flight RD_LAT=2 read: response is lost, outputs clear at once.
    req(1, 0, 3, 0, 0, 3, 0);
    idle(1);
    repeat (4) @(negedge CLK);
    chk("dut1_rdata_before_reset", 32'(rdata_s[1]), 32'h03);
    req_valid_s[1] = 1'b1;
    req_write_s[1] = 1'b0;
    addr_s[1]      = 8'd2;
    @(negedge CLK);
    idle(1);
    #1 RESET = 1'b1;
    #1;
    chk("dut1_async_reset_rvalid", 32'(rvalid_s[1]), 32'd0);
    chk("dut1_async_reset_rdata", 32'(rdata_s[1]), 32'd0);
    chk("dut1_async_reset_busy", 32'(busy_s[1]), 32'd1);
    chk("dut1_async_reset_ready", 32'(req_ready_s[1]), 32'd0);
    repeat (3) @(negedge CLK);
    chk("dut1_rvalid_in_reset", 32'(rvalid_s[1]), 32'd0);
    RESET = 1'b0;
    wait_sweep(1, 200, "dut1_sweep_after_reset", 0);
    req(1, 0, 0, 0, 0, 'h00, 0);
    req(1, 0, 2, 0, 0, 'h02, 0);
    idle(1);

    k = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    chk("scoreboard_drained", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
